// File: rtl/can_tx_scheduler_pkg.sv
// Shared CAN definitions: frame field widths and scheduler state encodings.
package can_tx_scheduler_pkg;

  localparam int unsigned CAN_ID_W   = 11;
  localparam int unsigned CAN_DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_BUSY   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } sched_state_t;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Host-write and transmitter-side signal bundle of the CAN TX scheduler.
//   sched_en, wr_*       : host control and mailbox write port
//   txing                : transmitter busy flag (asynchronous phase)
//   address_tx/tx_data   : frame presented to the transmitter
//   tx_start             : launch request
//   pend/busy/done/done_slot/err/wr_rej : status back to the host
// slave = scheduler side, master = host/transmitter side.
interface can_tx_scheduler_if #(
  parameter int unsigned NUM_SLOT = 4
);
  import can_tx_scheduler_pkg::*;

  localparam int unsigned SLOT_W = $clog2(NUM_SLOT);

  logic                  sched_en;
  logic                  wr_en;
  logic [SLOT_W-1:0]     wr_slot;
  logic [CAN_ID_W-1:0]   wr_id;
  logic [CAN_DATA_W-1:0] wr_data;
  logic                  txing;
  logic [CAN_ID_W-1:0]   address_tx;
  logic [CAN_DATA_W-1:0] tx_data;
  logic                  tx_start;
  logic [NUM_SLOT-1:0]   pend;
  logic                  busy;
  logic                  done;
  logic [SLOT_W-1:0]     done_slot;
  logic                  err;
  logic                  wr_rej;

  modport slave (
    input  sched_en, wr_en, wr_slot, wr_id, wr_data, txing,
    output address_tx, tx_data, tx_start, pend, busy, done, done_slot, err, wr_rej
  );

  modport master (
    output sched_en, wr_en, wr_slot, wr_id, wr_data, txing,
    input  address_tx, tx_data, tx_start, pend, busy, done, done_slot, err, wr_rej
  );

endinterface

// File: rtl/can_tx_scheduler_arbiter.sv
// can_id_arbiter: combinational selector over pending mailbox slots.
//   pend      : per-slot pending flags
//   ids       : stored CAN identifiers per slot
//   win_slot  : lowest-ID pending slot (ties go to the lowest index)
//   win_valid : at least one slot pending
module can_id_arbiter
  import can_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOT = 4
) (
  input  logic [NUM_SLOT-1:0]         pend,
  input  logic [CAN_ID_W-1:0]         ids [NUM_SLOT],
  output logic [$clog2(NUM_SLOT)-1:0] win_slot,
  output logic                        win_valid
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOT);

  logic [CAN_ID_W-1:0] best_id;

  // Strict less-than keeps the earlier (lower) index on equal IDs.
  always_comb begin
    win_valid = 1'b0;
    win_slot  = '0;
    best_id   = '1;
    for (int unsigned i = 0; i < NUM_SLOT; i++) begin
      if (pend[i] && (!win_valid || ids[i] < best_id)) begin
        win_valid = 1'b1;
        win_slot  = SLOT_W'(i);
        best_id   = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares one CAN transmitter among NUM_SLOT mailboxes,
// launching the lowest-ID pending frame and retiring it on completion.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : can_tx_scheduler_if.slave (writes, transmitter handshake, status)
// Parameters: NUM_SLOT mailbox count (2..8), TIMEOUT cycles allowed in
// START or BUSY before the frame is aborted (and later retried).
module can_tx_scheduler
  import can_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOT = 4,
  parameter int unsigned TIMEOUT  = 50000
) (
  input logic               clk,
  input logic               rst,
  can_tx_scheduler_if.slave bus
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOT);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [SLOT_W:0]   SLOT_LIM  = (SLOT_W + 1)'(NUM_SLOT);

  sched_state_t          state, state_nx;
  logic [CAN_ID_W-1:0]   id_mem   [NUM_SLOT];
  logic [CAN_DATA_W-1:0] data_mem [NUM_SLOT];
  logic [NUM_SLOT-1:0]   pend_q;
  logic [SLOT_W-1:0]     act_slot;
  logic [SLOT_W-1:0]     win_slot;
  logic                  win_valid;
  logic [CNT_W-1:0]      cnt;
  logic                  txing_m, txing_s;
  logic [CAN_ID_W-1:0]   addr_q;
  logic [CAN_DATA_W-1:0] data_q;
  logic [SLOT_W-1:0]     done_slot_q;
  logic                  wr_rej_q;
  logic                  act_locked, wr_in_range, wr_ok, wr_ref, sel_fwd;

  can_id_arbiter #(.NUM_SLOT(NUM_SLOT)) u_arb (
    .pend      (pend_q),
    .ids       (id_mem),
    .win_slot  (win_slot),
    .win_valid (win_valid)
  );

  assign act_locked  = (state != ST_IDLE) && (state != ST_SELECT);
  assign wr_in_range = {1'b0, bus.wr_slot} < SLOT_LIM;
  assign wr_ok       = bus.wr_en && wr_in_range && !(act_locked && (bus.wr_slot == act_slot));
  assign wr_ref      = bus.wr_en && !wr_ok;
  // A write landing on the winner during SELECT is forwarded so the frame
  // latched for the transmitter matches what ends up in storage.
  assign sel_fwd     = wr_ok && (bus.wr_slot == win_slot);

  // Mailbox storage and pending flags. A write to the active slot is refused
  // in DONE, so the clear and a write never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      for (int unsigned i = 0; i < NUM_SLOT; i++) begin
        id_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (state == ST_DONE) pend_q[act_slot] <= 1'b0;
      if (wr_ok) begin
        pend_q[bus.wr_slot]   <= 1'b1;
        id_mem[bus.wr_slot]   <= bus.wr_id;
        data_mem[bus.wr_slot] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      act_slot    <= '0;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      done_slot_q <= '0;
      wr_rej_q    <= 1'b0;
      txing_m     <= 1'b0;
      txing_s     <= 1'b0;
    end else begin
      state    <= state_nx;
      txing_m  <= bus.txing;
      txing_s  <= txing_m;
      wr_rej_q <= wr_ref;
      // Frame is captured on the SELECT->LOAD edge so it is already valid
      // during LOAD, one cycle ahead of tx_start.
      if (state == ST_SELECT && win_valid) begin
        act_slot <= win_slot;
        addr_q   <= sel_fwd ? bus.wr_id   : id_mem[win_slot];
        data_q   <= sel_fwd ? bus.wr_data : data_mem[win_slot];
      end
      case (state)
        ST_LOAD:  cnt <= '0;
        ST_START: begin
          if (state_nx == ST_BUSY)       cnt <= '0;
          else if (state_nx == ST_START) cnt <= cnt + CNT_W'(1);
        end
        ST_BUSY:  if (state_nx == ST_BUSY) cnt <= cnt + CNT_W'(1);
        default:  ;
      endcase
      if (state == ST_BUSY && state_nx == ST_DONE) done_slot_q <= act_slot;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.sched_en && (|pend_q)) state_nx = ST_SELECT;
      ST_SELECT: state_nx = win_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD:   state_nx = ST_START;
      ST_START: begin
        if (txing_s)              state_nx = ST_BUSY;
        else if (cnt == CNT_LAST) state_nx = ST_ERR;
      end
      ST_BUSY: begin
        if (!txing_s)             state_nx = ST_DONE;
        else if (cnt == CNT_LAST) state_nx = ST_ERR;
      end
      ST_DONE:   state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign bus.address_tx = addr_q;
  assign bus.tx_data    = data_q;
  assign bus.tx_start   = (state == ST_START);
  assign bus.pend       = pend_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.done_slot  = done_slot_q;
  assign bus.err        = (state == ST_ERR);
  assign bus.wr_rej     = wr_rej_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler with a small transmitter model.
module tb_can_tx_scheduler;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_tx_scheduler_if #(.NUM_SLOT(NS)) bus ();

  can_tx_scheduler #(.NUM_SLOT(NS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [10:0] id, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_slot = s;
    bus.wr_id   = id;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Transmitter model: waits for tx_start, raises txing rise_dly cycles later,
  // drops it hold cycles after raising, and reports what it observed.
  task automatic do_frame(input int rise_dly, input int hold, input bit drop_en,
                          output int start_wait, output int fall_lat, output int done_lat,
                          output logic [10:0] addr, output logic [63:0] data,
                          output logic [1:0] dslot, output bit stable, output bit pulse_ok);
    start_wait = 0;
    while (bus.tx_start !== 1'b1 && start_wait < 100) begin tick(); start_wait++; end
    addr   = bus.address_tx;
    data   = bus.tx_data;
    stable = 1'b1;
    for (int k = 0; k < rise_dly; k++) begin
      tick();
      if (bus.address_tx !== addr || bus.tx_data !== data) stable = 1'b0;
    end
    bus.txing = 1'b1;
    fall_lat = 0;
    while (bus.tx_start !== 1'b0 && fall_lat < 20) begin
      tick(); fall_lat++;
      if (bus.address_tx !== addr || bus.tx_data !== data) stable = 1'b0;
    end
    if (drop_en) bus.sched_en = 1'b0;
    for (int k = fall_lat; k < hold; k++) begin
      tick();
      if (bus.address_tx !== addr || bus.tx_data !== data) stable = 1'b0;
    end
    bus.txing = 1'b0;
    done_lat = 0;
    while (bus.done !== 1'b1 && done_lat < 20) begin
      tick(); done_lat++;
      if (bus.address_tx !== addr || bus.tx_data !== data) stable = 1'b0;
    end
    dslot = bus.done_slot;
    tick();
    pulse_ok = (bus.done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (bus.pend !== 4'b0000) begin n_fail++; $display("FAIL reset_pend got %b want 0000", bus.pend); end
    n_checks++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_busy_start got %b%b want 00", bus.busy, bus.tx_start); end
    n_checks++; if (bus.address_tx !== 11'h0 || bus.tx_data !== 64'h0) begin n_fail++; $display("FAIL reset_frame got %h/%h want 0/0", bus.address_tx, bus.tx_data); end
    n_checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.wr_rej !== 1'b0 || bus.done_slot !== 2'd0) begin
      n_fail++; $display("FAIL reset_status got done=%b err=%b rej=%b slot=%0d want 0", bus.done, bus.err, bus.wr_rej, bus.done_slot); end
  endtask

  task automatic test_single();
    int sw, fl, dl; logic [10:0] a; logic [63:0] d; logic [1:0] ds; bit st, po;
    bus.sched_en = 1'b1;
    wr(2'd2, 11'h123, 64'hDEADBEEF_01234567);
    n_checks++; if (bus.pend !== 4'b0100) begin n_fail++; $display("FAIL single_pend got %b want 0100", bus.pend); end
    tick();
    n_checks++; if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL single_select got busy=%b start=%b want 1/0", bus.busy, bus.tx_start); end
    tick();
    n_checks++; if (bus.address_tx !== 11'h123 || bus.tx_data !== 64'hDEADBEEF_01234567 || bus.tx_start !== 1'b0) begin
      n_fail++; $display("FAIL single_load_frame got %h/%h start=%b want 123/deadbeef01234567 start=0", bus.address_tx, bus.tx_data, bus.tx_start); end
    do_frame(10, 200, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (sw !== 1) begin n_fail++; $display("FAIL single_start_wait got %0d want 1", sw); end
    n_checks++; if (a !== 11'h123 || d !== 64'hDEADBEEF_01234567) begin n_fail++; $display("FAIL single_frame got %h/%h want 123/deadbeef01234567", a, d); end
    n_checks++; if (fl !== 3) begin n_fail++; $display("FAIL single_start_fall got %0d want 3", fl); end
    n_checks++; if (dl !== 3) begin n_fail++; $display("FAIL single_done_lat got %0d want 3", dl); end
    n_checks++; if (ds !== 2'd2) begin n_fail++; $display("FAIL single_done_slot got %0d want 2", ds); end
    n_checks++; if (st !== 1'b1 || po !== 1'b1) begin n_fail++; $display("FAIL single_stable_pulse got %b%b want 11", st, po); end
    n_checks++; if (bus.pend !== 4'b0000) begin n_fail++; $display("FAIL single_pend_clear got %b want 0000", bus.pend); end
  endtask

  task automatic test_priority();
    int sw, fl, dl; logic [10:0] a; logic [63:0] d; logic [1:0] ds; bit st, po, idle_ok;
    bus.sched_en = 1'b0;
    wr(2'd0, 11'h400, 64'h0000_0000_0000_00A0);
    wr(2'd1, 11'h010, 64'h0000_0000_0000_00A1);
    wr(2'd3, 11'h010, 64'h0000_0000_0000_00A3);
    n_checks++; if (bus.pend !== 4'b1011) begin n_fail++; $display("FAIL prio_pend got %b want 1011", bus.pend); end
    idle_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0) idle_ok = 1'b0; end
    n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL sched_off_idle got 0 want 1"); end
    bus.sched_en = 1'b1;
    do_frame(2, 20, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd1 || a !== 11'h010 || d !== 64'hA1) begin n_fail++; $display("FAIL prio_first got slot=%0d id=%h data=%h want 1/010/a1", ds, a, d); end
    do_frame(2, 20, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd3 || a !== 11'h010 || d !== 64'hA3) begin n_fail++; $display("FAIL prio_second got slot=%0d id=%h data=%h want 3/010/a3", ds, a, d); end
    // One IDLE cycle was already consumed by do_frame after done.
    n_checks++; if (sw !== 3) begin n_fail++; $display("FAIL back_to_back_gap got %0d want 3", sw); end
    do_frame(2, 20, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd0 || a !== 11'h400 || d !== 64'hA0) begin n_fail++; $display("FAIL prio_third got slot=%0d id=%h data=%h want 0/400/a0", ds, a, d); end
    n_checks++; if (bus.pend !== 4'b0000) begin n_fail++; $display("FAIL prio_pend_clear got %b want 0000", bus.pend); end
  endtask

  task automatic test_timeout();
    int n, m, sw, fl, dl; logic [10:0] a; logic [63:0] d; logic [1:0] ds; bit st, po;
    bus.sched_en = 1'b1;
    wr(2'd0, 11'h0AA, 64'h1111_2222_3333_4444);
    m = 0;
    while (bus.tx_start !== 1'b1 && m < 20) begin tick(); m++; end
    n = 0;
    while (bus.err !== 1'b1 && n < int'(TO) + 20) begin tick(); n++; end
    n_checks++; if (n !== int'(TO)) begin n_fail++; $display("FAIL timeout_lat got %0d want %0d", n, TO); end
    n_checks++; if (bus.pend !== 4'b0001 || bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL timeout_keep got pend=%b start=%b want 0001/0", bus.pend, bus.tx_start); end
    tick();
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse got 1 want 0"); end
    m = 1;
    while (bus.tx_start !== 1'b1 && m < 20) begin tick(); m++; end
    n_checks++; if (m !== 4) begin n_fail++; $display("FAIL timeout_retry got %0d want 4", m); end
    do_frame(5, 30, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd0 || dl !== 3 || a !== 11'h0AA) begin n_fail++; $display("FAIL timeout_retry_done got slot=%0d lat=%0d id=%h want 0/3/0aa", ds, dl, a); end
    n_checks++; if (bus.pend !== 4'b0000) begin n_fail++; $display("FAIL timeout_pend_clear got %b want 0000", bus.pend); end
  endtask

  task automatic test_refused();
    int m, sw, fl, dl; logic [10:0] a; logic [63:0] d; logic [1:0] ds; bit st, po;
    bus.sched_en = 1'b1;
    wr(2'd2, 11'h055, 64'hAAAA_0000_0000_5555);
    m = 0;
    while (bus.tx_start !== 1'b1 && m < 20) begin tick(); m++; end
    bus.txing = 1'b1;
    m = 0;
    while (bus.tx_start !== 1'b0 && m < 20) begin tick(); m++; end
    wr(2'd2, 11'h7FF, 64'hBBBB_BBBB_BBBB_BBBB);
    n_checks++; if (bus.wr_rej !== 1'b1) begin n_fail++; $display("FAIL refuse_active got %b want 1", bus.wr_rej); end
    wr(2'd1, 11'h300, 64'hCCCC_0000_0000_CCCC);
    n_checks++; if (bus.wr_rej !== 1'b0 || bus.pend !== 4'b0110) begin n_fail++; $display("FAIL accept_other got rej=%b pend=%b want 0/0110", bus.wr_rej, bus.pend); end
    n_checks++; if (bus.address_tx !== 11'h055 || bus.tx_data !== 64'hAAAA_0000_0000_5555) begin n_fail++; $display("FAIL refuse_frame got %h/%h want 055/aaaa000000005555", bus.address_tx, bus.tx_data); end
    bus.txing = 1'b0;
    m = 0;
    while (bus.done !== 1'b1 && m < 20) begin tick(); m++; end
    n_checks++; if (bus.done_slot !== 2'd2 || m !== 3) begin n_fail++; $display("FAIL refuse_done got slot=%0d lat=%0d want 2/3", bus.done_slot, m); end
    tick();
    n_checks++; if (bus.pend !== 4'b0010) begin n_fail++; $display("FAIL refuse_pend got %b want 0010", bus.pend); end
    do_frame(3, 10, 1'b0, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd1 || a !== 11'h300 || d !== 64'hCCCC_0000_0000_CCCC) begin n_fail++; $display("FAIL refuse_next got slot=%0d id=%h data=%h want 1/300/cccc00000000cccc", ds, a, d); end
  endtask

  task automatic test_sched_mid();
    int sw, fl, dl; logic [10:0] a; logic [63:0] d; logic [1:0] ds; bit st, po, idle_ok;
    bus.sched_en = 1'b1;
    wr(2'd3, 11'h111, 64'h0000_0000_0000_0333);
    wr(2'd1, 11'h222, 64'h0000_0000_0000_0111);
    do_frame(4, 12, 1'b1, sw, fl, dl, a, d, ds, st, po);
    n_checks++; if (ds !== 2'd3 || dl !== 3) begin n_fail++; $display("FAIL sched_mid_done got slot=%0d lat=%0d want 3/3", ds, dl); end
    idle_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) idle_ok = 1'b0; end
    n_checks++; if (idle_ok !== 1'b1 || bus.pend !== 4'b0010) begin n_fail++; $display("FAIL sched_mid_idle got idle=%b pend=%b want 1/0010", idle_ok, bus.pend); end
  endtask

  task automatic test_reset_mid();
    int m;
    bus.sched_en = 1'b1;
    m = 0;
    while (bus.tx_start !== 1'b1 && m < 20) begin tick(); m++; end
    n_checks++; if (bus.tx_start !== 1'b1 || bus.address_tx !== 11'h222) begin n_fail++; $display("FAIL reset_mid_pre got start=%b id=%h want 1/222", bus.tx_start, bus.address_tx); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.tx_start !== 1'b0 || bus.pend !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ctl got start=%b pend=%b busy=%b want 0/0000/0", bus.tx_start, bus.pend, bus.busy); end
    n_checks++; if (bus.address_tx !== 11'h0 || bus.tx_data !== 64'h0 || bus.done_slot !== 2'd0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.wr_rej !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_out got id=%h data=%h slot=%0d done=%b err=%b rej=%b want zeros", bus.address_tx, bus.tx_data, bus.done_slot, bus.done, bus.err, bus.wr_rej); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stay got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    bus.sched_en = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_slot  = '0;
    bus.wr_id    = '0;
    bus.wr_data  = '0;
    bus.txing    = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_timeout();
    test_refused();
    test_sched_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
